// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - Host/decoder-to-sequencer signal bundle for fetch_sequencer
interface fetch_sequencer_if #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 32
);
    logic             start;
    logic [PC_W-1:0]  start_addr;
    logic [8:0]       instruction;
    logic             branch;
    logic             zero;
    logic             halt;
    logic             stall;
    logic [PC_W-1:0]  pc;
    logic             instr_valid;
    logic             taken;
    logic             done;
    logic [CNT_W-1:0] retired;

    modport master (
        output start, start_addr, instruction, branch, zero, halt, stall,
        input  pc, instr_valid, taken, done, retired
    );

    modport slave (
        input  start, start_addr, instruction, branch, zero, halt, stall,
        output pc, instr_valid, taken, done, retired
    );
endinterface

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC register with run/halt FSM, PC-relative branching and retire counter
module fetch_sequencer #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    fetch_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t           state;
    logic [PC_W-1:0]  pc_q;
    logic [CNT_W-1:0] retired_q;

    logic             instr_valid_c;
    logic             taken_c;
    logic [PC_W-1:0]  offset;
    logic [PC_W-1:0]  pc_seq;
    logic [PC_W-1:0]  pc_target;
    logic [CNT_W-1:0] retired_inc;
    logic             unused_instr_bits;

    assign instr_valid_c = (state == RUN) && !bus.stall;
    assign taken_c       = instr_valid_c && !bus.halt && bus.branch && bus.zero;

    // Only the low 7 bits carry the branch offset; the opcode bits belong to the decoder.
    assign offset            = {{(PC_W-7){bus.instruction[6]}}, bus.instruction[6:0]};
    assign unused_instr_bits = &{1'b0, bus.instruction[8:7]};

    assign pc_seq      = pc_q + PC_W'(1);
    assign pc_target   = pc_seq + offset;
    assign retired_inc = (&retired_q) ? retired_q : retired_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pc_q      <= '0;
            retired_q <= '0;
        end else begin
            case (state)
                IDLE, HALTED: begin
                    if (bus.start) begin
                        state     <= RUN;
                        pc_q      <= bus.start_addr;
                        retired_q <= '0;
                    end
                end
                RUN: begin
                    // A stalled cycle freezes everything; halt/branch are only meaningful once it retires.
                    if (!bus.stall) begin
                        retired_q <= retired_inc;
                        if (bus.halt)
                            state <= HALTED;
                        else if (taken_c)
                            pc_q <= pc_target;
                        else
                            pc_q <= pc_seq;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.pc          = pc_q;
    assign bus.retired     = retired_q;
    assign bus.instr_valid = instr_valid_c;
    assign bus.taken       = taken_c;
    assign bus.done        = (state == HALTED);
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - Scoreboard-driven self-checking bench for fetch_sequencer
module tb_fetch_sequencer;
    logic clk;
    logic reset;

    fetch_sequencer_if #(.PC_W(32), .CNT_W(32)) bus ();

    fetch_sequencer #(.PC_W(32), .CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ret;
        logic        done;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    int          m_state;   // 0 idle, 1 run, 2 halted
    logic [31:0] m_pc;
    logic [31:0] m_ret;

    // One clock cycle: drive at negedge, check decode-side outputs, predict, then check registers after the edge.
    task automatic cycle(input logic st, input logic [31:0] sa, input logic [8:0] ins,
                         input logic br, input logic z, input logic h, input logic s,
                         input logic rst);
        logic exp_iv, exp_tk, exp_dn;
        exp_t e, got;
        @(negedge clk);
        reset           = rst;
        bus.start       = st;
        bus.start_addr  = sa;
        bus.instruction = ins;
        bus.branch      = br;
        bus.zero        = z;
        bus.halt        = h;
        bus.stall       = s;
        #1;
        exp_iv = (m_state == 1) && !s;
        exp_tk = exp_iv && !h && br && z;
        exp_dn = (m_state == 2);
        checks++;
        if (bus.instr_valid !== exp_iv) begin
            errors++;
            $display("FAIL instr_valid: got %b want %b at pc=%h", bus.instr_valid, exp_iv, m_pc);
        end
        checks++;
        if (bus.taken !== exp_tk) begin
            errors++;
            $display("FAIL taken: got %b want %b at pc=%h", bus.taken, exp_tk, m_pc);
        end
        if (rst) begin
            m_state = 0; m_pc = 0; m_ret = 0;
        end else if (m_state != 1) begin
            if (st) begin
                m_state = 1; m_pc = sa; m_ret = 0;
            end
        end else if (!s) begin
            if (m_ret != 32'hFFFF_FFFF) m_ret = m_ret + 1;
            if (h)
                m_state = 2;
            else if (exp_tk)
                m_pc = m_pc + 32'd1 + {{25{ins[6]}}, ins[6:0]};
            else
                m_pc = m_pc + 32'd1;
        end
        e.pc = m_pc; e.ret = m_ret; e.done = (m_state == 2);
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        checks++;
        if (bus.pc !== got.pc) begin
            errors++;
            $display("FAIL pc: got %h want %h", bus.pc, got.pc);
        end
        checks++;
        if (bus.retired !== got.ret) begin
            errors++;
            $display("FAIL retired: got %0d want %0d", bus.retired, got.ret);
        end
        checks++;
        if (bus.done !== got.done) begin
            errors++;
            $display("FAIL done: got %b want %b", bus.done, got.done);
        end
    endtask

    task automatic step();
        cycle(1'b0, 32'h0, 9'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic go(input logic [31:0] addr);
        cycle(1'b0, 32'h0, 9'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, addr, 9'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic expect_pc(input string name, input logic [31:0] want);
        checks++;
        if (bus.pc !== want) begin
            errors++;
            $display("FAIL %s: pc got %h want %h", name, bus.pc, want);
        end
    endtask

    task automatic test_reset();
        cycle(1'b0, 32'h0, 9'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 9'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step();
        expect_pc("reset_idle", 32'h0);
    endtask

    task automatic test_straight();
        go(32'h10);
        expect_pc("straight_first", 32'h10);
        step(); step(); step();
        expect_pc("straight_fourth", 32'h13);
        cycle(1'b0, 32'h0, 9'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (bus.done !== 1'b1 || bus.retired !== 32'd4) begin
            errors++;
            $display("FAIL straight_halt: done=%b retired=%0d want done=1 retired=4", bus.done, bus.retired);
        end
        step();
        expect_pc("straight_hold", 32'h13);
    endtask

    task automatic test_branch();
        go(32'h20);
        cycle(1'b0, 32'h0, 9'h07C, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_pc("branch_back", 32'h1D);
        go(32'h20);
        cycle(1'b0, 32'h0, 9'h07C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_pc("branch_not_taken", 32'h21);
        go(32'h20);
        cycle(1'b0, 32'h0, 9'h03F, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_pc("branch_fwd", 32'h60);
    endtask

    task automatic test_stall();
        go(32'h30);
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 32'h0, 9'h07C, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        expect_pc("stall_hold", 32'h30);
        cycle(1'b0, 32'h0, 9'h000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (bus.done !== 1'b1 || bus.retired !== 32'd1) begin
            errors++;
            $display("FAIL stall_release: done=%b retired=%0d want done=1 retired=1", bus.done, bus.retired);
        end
    endtask

    task automatic test_wrap();
        go(32'hFFFF_FFFF);
        step();
        expect_pc("wrap_seq", 32'h0);
        go(32'h2);
        cycle(1'b0, 32'h0, 9'h040, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_pc("wrap_branch", 32'hFFFF_FFC3);
    endtask

    task automatic test_restart();
        go(32'h50);
        step(); step(); step();
        cycle(1'b0, 32'h0, 9'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 32'h40, 9'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.done !== 1'b0 || bus.retired !== 32'd0) begin
            errors++;
            $display("FAIL restart: done=%b retired=%0d want done=0 retired=0", bus.done, bus.retired);
        end
        expect_pc("restart_pc", 32'h40);
        cycle(1'b1, 32'h99, 9'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_pc("start_in_run_ignored", 32'h41);
        cycle(1'b1, 32'h77, 9'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        expect_pc("mid_run_reset", 32'h0);
        step();
        expect_pc("reset_stays_idle", 32'h0);
    endtask

    task automatic test_back_to_back();
        logic [8:0] ins;
        go(32'h100);
        for (int i = 0; i < 60; i++) begin
            ins = 9'($urandom_range(0, 511));
            if (m_state == 2)
                cycle(1'b1, $urandom, ins, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            else
                cycle($urandom_range(0, 1) == 1, $urandom, ins,
                      $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                      $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0, 1'b0);
        end
    endtask

    initial begin
        m_state = 0; m_pc = 0; m_ret = 0;
        reset = 1'b1;
        bus.start = 1'b0; bus.start_addr = '0; bus.instruction = '0;
        bus.branch = 1'b0; bus.zero = 1'b0; bus.halt = 1'b0; bus.stall = 1'b0;
        @(posedge clk);
        test_reset();
        test_straight();
        test_branch();
        test_stall();
        test_wrap();
        test_restart();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Program-counter sequencer for the 9-bit-instruction core. Owns the architectural PC register and a run/halt state machine, and computes the next PC each cycle from sequential increment or a taken PC-relative branch. Sits between the instruction memory (addressed by `pc`) and the decode/ALU stage (which supplies `branch`, `zero`, `halt`, `stall`). Provides a start/done handshake to the testbench or host and a retired-instruction counter.

## Interface

Parameters:
- `PC_W`, default 32: PC and address width.
- `CNT_W`, default 32: retired-instruction counter width.

Ports:
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `reset`  in  1  — synchronous, active-high.
- `start`  in  1  — one-cycle request to begin execution at `start_addr`.
- `start_addr`  in  PC_W  — entry address, sampled only when `start` is accepted.
- `instruction`  in  9  — instruction word at the current `pc`, read combinationally from imem.
- `branch`  in  1  — decoder: the current instruction is a conditional branch.
- `zero`  in  1  — ALU zero flag for the current instruction.
- `halt`  in  1  — decoder: the current instruction is HALT.
- `stall`  in  1  — hold the current instruction; no PC advance.
- `pc`  out  PC_W  — current PC, registered.
- `instr_valid`  out  1  — the current instruction executes (retires) this cycle.
- `taken`  out  1  — the branch is taken this cycle.
- `done`  out  1  — program halted; a level signal.
- `retired`  out  CNT_W  — count of retired instructions since the last accepted start.

## Operation

- States: IDLE, RUN, HALTED.
- Combinational outputs:
  - `instr_valid = (state==RUN) & ~stall`.
  - `taken = instr_valid & ~halt & branch & zero`.
  - `done = (state==HALTED)`.
- Branch target = `pc + 1 + sext(instruction[6:0])`.
  - Offset is 7-bit two's complement, range −64..+63, sign-extended to PC_W.
  - Arithmetic is modulo 2^PC_W; wrap in either direction is legal, and no error is flagged.
- Sequential increment = `pc + 1`, also modulo 2^PC_W. From all-ones, `pc` wraps to 0.
- IDLE:
  - `start`=1 → RUN, `pc`←`start_addr`, `retired`←0.
  - Otherwise hold.
- RUN, in priority order:
  1. `stall`=1: `pc`, `retired` and state all hold. `halt`, `branch` and `zero` are ignored.
  2. `halt`=1: → HALTED, `pc` holds at the HALT address, `retired`←`retired`+1. HALT counts as retired. `branch` is ignored.
  3. `taken`: `pc`←target, `retired`+1.
  4. Otherwise: `pc`←`pc`+1, `retired`+1.
  - `start` is ignored in RUN.
- HALTED:
  - `pc` and `retired` hold for readout.
  - `start`=1 → RUN, `pc`←`start_addr`, `retired`←0, `done` drops the next cycle.
- `retired` saturates at all-ones and does not wrap.
- `reset`=1 overrides everything, in any state including mid-RUN or during a stall. Next cycle values:
  - state=IDLE, `pc`=0, `retired`=0.
  - `done`=0, `instr_valid`=0, `taken`=0.

## Timing

- The PC register updates on the edge that ends the cycle in which `instr_valid` is high. There are no branch delay slots and no penalty: a taken branch's target appears in `pc` one cycle later.
- `start` → `pc`=`start_addr` and `instr_valid`=1 (if `stall`=0) on the following cycle, so start latency is 1 cycle.
- HALT retiring in cycle N → `done`=1 from cycle N+1.
- `stall` is sampled every RUN cycle. Each stalled cycle adds exactly one cycle to execution.
- Inputs `branch`, `zero`, `halt` and `instruction` must be valid and stable before the rising edge of any cycle with `instr_valid`=1.
- `start` and `reset` asserted in the same cycle: `reset` wins and state is IDLE.

## Test plan

- Reset then idle: hold `reset` 2 cycles, then 5 cycles with no start → `pc`=0, `done`=0, `instr_valid`=0, `retired`=0 throughout.
- Straight line: `start_addr`=0x10, no branches, `halt` at the 4th instruction → `pc` sequence 0x10, 0x11, 0x12, 0x13; `done`=1 the next cycle; `retired`=4; `pc` holds at 0x13.
- Branches at `pc`=0x20:
  - `instruction[6:0]`=7'h7C (−4), `branch`=1, `zero`=1 → `taken`=1, next `pc`=0x1D.
  - Same with `zero`=0 → next `pc`=0x21.
  - Offset 7'h3F → 0x60.
- Stall priority: at `pc`=0x30 assert `stall` for 3 cycles together with `halt`=1, `branch`=1, `zero`=1 → `pc` holds at 0x30, `retired` unchanged, `done`=0. Then release with `halt`=1 → HALTED.
- Wrap: `start_addr`=0xFFFF_FFFF, sequential → `pc`=0x0000_0000. From `pc`=0x2 with offset −64, taken → `pc`=0xFFFF_FFC3.
- Restart and mid-run reset:
  - From HALTED with `retired`=4, pulse `start` with `start_addr`=0x40 → `done` falls, `pc`=0x40, `retired`=0.
  - Assert `reset` mid-RUN → IDLE, `pc`=0, `retired`=0 the next cycle.
  - `start` pulsed during RUN is ignored.
